// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, adc_ctrl bit map and counter width for the ADC sequencer
package adc_pkg;
  typedef enum logic [2:0] {ADC_RST, IDLE, CONVST, WAIT_HI, WAIT_LO, READ, PUSH} state_t;
  localparam int CTRL_CONVST = 0, CTRL_RESET = 1, CTRL_RANGE = 2, CTRL_OS = 3, CTRL_STBY_N = 6;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: SCLK generator and MSB-first shift register for one ADC sample word
module adc_serial_rx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   done,
  output logic [SAMPLE_BITS-1:0] data
);
  localparam int DW = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(SAMPLE_BITS + 1);
  logic          busy, tog;
  logic [DW-1:0] div;
  logic [BW-1:0] bits;
  assign tog = busy && div == DW'(SCLK_DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk <= 1'b1;
      done <= 1'b0;
      busy <= 1'b0;
      div  <= '0;
      bits <= '0;
      data <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        sclk <= 1'b0;
        div  <= '0;
        bits <= '0;
      end else if (busy) begin
        div <= tog ? '0 : div + 1'b1;
        if (tog) sclk <= ~sclk;
        // MISO is captured on the edge that raises SCLK; SCLK then idles high
        if (tog && !sclk) begin
          data <= {data[SAMPLE_BITS-2:0], miso};
          bits <= bits + 1'b1;
          if (bits == BW'(SAMPLE_BITS - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: per-tick CONVST/BUSY/serial-read sequencing of an 8-channel ADC into a valid/ready stream
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int SCLK_DIV = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int RESET_CYCLES = 8,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sample_tick,
  input  logic [2:0]             os_ratio,
  input  logic                   range_sel,
  output logic [6:0]             adc_ctrl,
  input  logic                   adc_busy,
  output logic                   adc_sclk,
  output logic                   adc_cs_n,
  input  logic                   adc_miso,
  output logic                   smp_valid,
  input  logic                   smp_ready,
  output logic [SAMPLE_BITS-1:0] smp_data,
  output logic [2:0]             smp_chan,
  output logic                   smp_last,
  output logic [CNT_W-1:0]       overrun_cnt,
  output logic [CNT_W-1:0]       timeout_cnt
);
  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             ch, os_q;
  logic                   range_q, convst, adc_rst, rx_start, rx_done, wait_to;
  logic [SAMPLE_BITS-1:0] rx_data;
  adc_serial_rx #(.SAMPLE_BITS(SAMPLE_BITS), .SCLK_DIV(SCLK_DIV)) u_rx (
    .clk, .reset_n, .start(rx_start), .miso(adc_miso), .sclk(adc_sclk), .done(rx_done), .data(rx_data)
  );
  assign wait_to = cnt == CNT_W'(BUSY_TIMEOUT - 1);
  assign smp_chan = ch;
  assign smp_last = smp_valid && ch == 3'(NUM_CH - 1);
  always_comb begin
    adc_ctrl = '0;
    adc_ctrl[CTRL_CONVST] = convst;
    adc_ctrl[CTRL_RESET] = adc_rst;
    adc_ctrl[CTRL_RANGE] = range_q;
    adc_ctrl[CTRL_OS +: 3] = os_q;
    adc_ctrl[CTRL_STBY_N] = 1'b1;
  end
  always_comb begin
    state_nx = state;
    case (state)
      ADC_RST: state_nx = cnt == CNT_W'(RESET_CYCLES - 1) ? IDLE : ADC_RST;
      IDLE:    state_nx = sample_tick && enable ? CONVST : IDLE;
      CONVST:  state_nx = cnt == CNT_W'(CONVST_CYCLES - 1) ? WAIT_HI : CONVST;
      WAIT_HI: state_nx = adc_busy ? WAIT_LO : wait_to ? IDLE : WAIT_HI;
      WAIT_LO: state_nx = !adc_busy ? READ : wait_to ? IDLE : WAIT_LO;
      READ:    state_nx = rx_done ? PUSH : READ;
      PUSH:    state_nx = !smp_ready ? PUSH : ch == 3'(NUM_CH - 1) ? IDLE : READ;
      default: state_nx = ADC_RST;
    endcase
  end
  // ADC-facing strobes are registered from the next state so they switch cleanly with it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= ADC_RST;
      cnt         <= '0;
      ch          <= '0;
      os_q        <= '0;
      range_q     <= 1'b0;
      convst      <= 1'b1;
      adc_rst     <= 1'b1;
      rx_start    <= 1'b0;
      adc_cs_n    <= 1'b1;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= state_nx == state ? cnt + 1'b1 : '0;
      convst    <= state_nx != CONVST;
      adc_rst   <= state_nx == ADC_RST;
      rx_start  <= state_nx == READ && state != READ;
      adc_cs_n  <= !(state_nx == READ || state_nx == PUSH);
      smp_valid <= state_nx == PUSH;
      ch        <= state == WAIT_LO ? '0 : state == PUSH && state_nx == READ ? ch + 1'b1 : ch;
      if (rx_done) smp_data <= rx_data;
      if (state == IDLE) begin
        os_q    <= os_ratio;
        range_q <= range_sel;
      end
      if (sample_tick && !(state == IDLE && enable)) overrun_cnt <= sat_inc(overrun_cnt);
      if ((state == WAIT_HI || state == WAIT_LO) && state_nx == IDLE) timeout_cnt <= sat_inc(timeout_cnt);
    end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: ADC model plus scoreboard of expected frames for adc_sample_sequencer
module tb_adc_sample_sequencer;
  logic clk = 0, reset_n = 0, enable = 0, sample_tick = 0, range_sel = 0;
  logic adc_busy = 0, adc_miso = 0, smp_ready = 1;
  logic [2:0] os_ratio = 0;
  logic [6:0] adc_ctrl;
  logic adc_sclk, adc_cs_n, smp_valid, smp_last;
  logic [15:0] smp_data, overrun_cnt, timeout_cnt;
  logic [2:0] smp_chan;
  typedef struct {logic [15:0] d; logic [2:0] c; logic l;} smp_t;
  smp_t exp_q[$];
  logic [15:0] words[8];
  logic [15:0] last_seen;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  int exp_ovr = 0, exp_to = 0, busy_len = 3, rdy_mode = 0, bitpos = 0;
  bit in_frame = 0, busy_en = 1;

  adc_sample_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_tick(sample_tick),
    .os_ratio(os_ratio), .range_sel(range_sel), .adc_ctrl(adc_ctrl), .adc_busy(adc_busy),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_miso(adc_miso), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .smp_data(smp_data), .smp_chan(smp_chan), .smp_last(smp_last),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #600000; $display("FAIL watchdog expired"); $fatal(1); end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC serial side: next bit of the frame appears on each SCLK fall, words streamed in channel order
  initial forever begin
    @(negedge adc_sclk or posedge adc_cs_n);
    if (adc_cs_n) bitpos = 0;
    else if (bitpos < 128) begin
      adc_miso = words[bitpos / 16][15 - bitpos % 16];
      bitpos++;
    end
  end

  // ADC BUSY: rises shortly after CONVST returns high, held busy_len cycles
  initial forever begin
    @(negedge adc_ctrl[0]);
    @(posedge adc_ctrl[0]);
    if (busy_en) begin
      repeat (2) @(posedge clk);
      #1 adc_busy = 1;
      repeat (busy_len) @(posedge clk);
      #1 adc_busy = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 smp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) : ($urandom % 3 != 0);
  end

  // stream checker: every accepted sample against the scoreboard, plus hold/timing rules
  initial begin
    logic [15:0] pd;
    logic [2:0] pc;
    bit pstall;
    int pvcyc;
    smp_t e;
    pstall = 0;
    pvcyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !smp_valid) pstall = 0;
      else begin
        if (pstall) begin
          chk("stall_data", smp_data, pd);
          chk("stall_chan", smp_chan, pc);
        end
        chk("cs_low_on_valid", adc_cs_n, 0);
        if (smp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_sample", smp_data, 32'hDEAD_0000);
          else begin
            e = exp_q.pop_front();
            chk("data", smp_data, e.d);
            chk("chan", smp_chan, e.c);
            chk("last", smp_last, e.l);
          end
          if (rdy_mode == 0 && smp_chan != 0) chk("chan_period", cyc - pvcyc, 65);
          pvcyc = cyc;
          acc_cnt++;
          last_seen = smp_data;
        end
        pstall = !smp_ready;
        pd = smp_data;
        pc = smp_chan;
      end
    end
  end

  // model: a tick starts a frame only when enabled and no frame is in flight, otherwise it is an overrun
  task automatic tick();
    bit acc;
    acc = enable && !in_frame;
    @(posedge clk); #1 sample_tick = 1;
    @(posedge clk); #1 sample_tick = 0;
    if (!acc) exp_ovr++;
    else begin
      chk("convst_low_next_cycle", adc_ctrl[0], 0);
      in_frame = 1;
      if (busy_en) for (int i = 0; i < 8; i++) exp_q.push_back('{words[i], 3'(i), i == 7});
      else exp_to++;
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !adc_cs_n) && n < 3000) begin @(negedge clk); n++; end
    chk("frame_done_in_time", n < 3000, 1);
    in_frame = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset_n = 0;
    #1;
    chk("rst_ctrl", adc_ctrl, 7'h43);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_chan", smp_chan, 0);
    chk("rst_last", smp_last, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_to", timeout_cnt, 0);
    exp_q.delete();
    in_frame = 0;
    exp_ovr = 0;
    exp_to = 0;
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      chk("adc_reset_high", adc_ctrl[1], 1);
      @(posedge clk); #1;
    end
    chk("adc_reset_low", adc_ctrl[1], 0);
  endtask

  task automatic chk_counters();
    chk("overrun_cnt", overrun_cnt, exp_ovr);
    chk("timeout_cnt", timeout_cnt, exp_to);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) words[i] = 16'h1000 + 16'(i);
    do_reset();
    enable = 1;
    os_ratio = 3'd5;
    range_sel = 1;
    repeat (2) @(posedge clk);
    #1 chk("os_track", adc_ctrl[5:3], 5);
    chk("range_track", adc_ctrl[2], 1);
    chk("stby_n", adc_ctrl[6], 1);
    // frame 1, ready held high; inputs changed mid-frame must not reach adc_ctrl
    tick();
    os_ratio = 3'd2;
    range_sel = 0;
    repeat (5) @(posedge clk);
    #1 chk("os_frozen", adc_ctrl[5:3], 5);
    chk("range_frozen", adc_ctrl[2], 1);
    wait_frame();
    chk("frame1_count", acc_cnt, 8);
    chk("frame1_last_word", last_seen, 16'h1007);
    repeat (3) @(posedge clk);
    #1 chk("os_track_again", adc_ctrl[5:3], 2);
    // frame 2, ready one cycle in three
    rdy_mode = 1;
    tick();
    wait_frame();
    chk("frame2_count", acc_cnt, 16);
    // second tick while reading
    rdy_mode = 0;
    tick();
    repeat (60) @(posedge clk);
    tick();
    wait_frame();
    chk("overrun_literal", overrun_cnt, 1);
    chk_counters();
    // BUSY never rises
    busy_en = 0;
    tick();
    repeat (200) @(posedge clk);
    #1 chk("timeout_not_yet", timeout_cnt, 0);
    repeat (100) @(posedge clk);
    #1 chk("timeout_literal", timeout_cnt, 1);
    in_frame = 0;
    busy_en = 1;
    tick();
    wait_frame();
    chk_counters();
    // disabled tick, then enable dropped mid-frame
    enable = 0;
    tick();
    enable = 1;
    tick();
    repeat (30) @(posedge clk);
    enable = 0;
    wait_frame();
    enable = 1;
    chk_counters();
    // randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
      rdy_mode = $urandom % 3;
      busy_len = 1 + $urandom % 20;
      os_ratio = 3'($urandom);
      tick();
      if ($urandom % 2 == 1) begin
        repeat (40 + $urandom % 200) @(posedge clk);
        tick();
      end
      wait_frame();
      chk_counters();
    end
    // reset in the middle of channel 3
    rdy_mode = 0;
    tick();
    n = 0;
    while (!(smp_valid && smp_chan == 3) && n < 2000) begin @(negedge clk); n++; end
    chk("reach_chan3", n < 2000, 1);
    do_reset();
    enable = 1;
    n = acc_cnt;
    tick();
    wait_frame();
    chk("post_reset_frame_count", acc_cnt - n, 8);
    chk_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
